// File: rtl/ram_access_initiator.sv
// ram_access_initiator
//   CPU-side master for a byte-addressed, little-endian data RAM with a
//   combinational read port and a level-sensitive write strobe. Accepts one
//   load/store at a time, sequences the RAM strobes so read and write are
//   never high together, does read-modify-write for byte/halfword stores and
//   returns sign/zero-extended load data (LB/LBU/LH/LHU/LW, SB/SH/SW).
//
//   Optional feature: define RAM_ACCESS_RANGE_CHECK_EN to flag any access whose
//   highest byte address is >= RAM_BYTES as an error with no RAM access.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_write         1=store, 0=load
//   req_size          0=byte, 1=half, 2=word, 3=reserved (error)
//   req_signed        sign-extend load result
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores/errors)
//   resp_err          misaligned / reserved size / out of range
//   ram_addr          RAM address
//   ram_wdata         RAM write data
//   ram_data_read     RAM read strobe
//   ram_data_write    RAM write strobe
//   ram_rdata         RAM read data
module ram_access_initiator #(
  parameter int unsigned RAM_BYTES = 1001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_data_read,
  output logic        ram_data_write,
  input  logic [31:0] ram_rdata
);

`ifdef RAM_ACCESS_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif
  localparam logic [32:0] LAST_BYTE = 33'(RAM_BYTES) - 33'd1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state, state_nxt;
  logic        capture;
  logic        ready_nxt, resp_valid_nxt, resp_err_nxt, rd_nxt, wr_nxt;
  logic [31:0] resp_rdata_nxt, ram_addr_nxt, ram_wdata_nxt;

  // Request fields held for the duration of the access
  logic        write_p0, signed_p0;
  logic [1:0]  size_p0, lane_p0;
  logic [31:0] wdata_p0;

  // Misalignment, reserved size and (optionally) out-of-range detection.
  // The highest byte is computed 33 bits wide so addresses near 2^32 cannot wrap.
  function automatic logic req_bad(input logic [1:0] size, input logic [31:0] addr);
    logic [32:0] hi;
    logic        bad;
    case (size)
      2'd0:    begin bad = 1'b0;      hi = {1'b0, addr};          end
      2'd1:    begin bad = addr[0];   hi = {1'b0, addr} + 33'd1;  end
      2'd2:    begin bad = |addr[1:0]; hi = {1'b0, addr} + 33'd3; end
      default: begin bad = 1'b1;      hi = {1'b0, addr};          end
    endcase
    return bad | (RANGE_CHECK & (hi > LAST_BYTE));
  endfunction

  // Select the addressed lane and extend it to 32 bits
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    ext = word;
    if (size == 2'd0) begin
      if (sgn) ext = 32'(b);
      else     ext = {24'd0, b};
    end else if (size == 2'd1) begin
      if (sgn) ext = 32'(h);
      else     ext = {16'd0, h};
    end
    return ext;
  endfunction

  // Replace the addressed byte/half lane of the read word with the store data
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    if (size == 2'd0)      r[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (size == 2'd1) begin
      if (lane[1]) r[31:16] = wdata[15:0];
      else         r[15:0]  = wdata[15:0];
    end else       r = wdata;
    return r;
  endfunction

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_nxt      = state;
    capture        = 1'b0;
    ready_nxt      = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_err_nxt   = 1'b0;
    resp_rdata_nxt = 32'd0;
    ram_addr_nxt   = ram_addr;
    ram_wdata_nxt  = ram_wdata;
    rd_nxt         = 1'b0;
    wr_nxt         = 1'b0;
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (req_valid && req_ready) begin
          capture   = 1'b1;
          ready_nxt = 1'b0;
          if (req_bad(req_size, req_addr)) begin
            state_nxt      = RESP;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
          end else if (req_write && req_size == 2'd2) begin
            state_nxt     = WRITE;
            ram_addr_nxt  = req_addr;
            ram_wdata_nxt = req_wdata;
            wr_nxt        = 1'b1;
          end else begin
            state_nxt    = READ;
            ram_addr_nxt = {req_addr[31:2], 2'b00};
            rd_nxt       = 1'b1;
          end
        end
      end
      READ: begin
        if (write_p0) begin
          state_nxt     = WRITE;
          ram_wdata_nxt = store_merge(ram_rdata, lane_p0, size_p0, wdata_p0);
          wr_nxt        = 1'b1;
        end else begin
          state_nxt      = RESP;
          resp_valid_nxt = 1'b1;
          resp_rdata_nxt = load_extend(ram_rdata, lane_p0, size_p0, signed_p0);
        end
      end
      WRITE: begin
        state_nxt      = RESP;
        resp_valid_nxt = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
    endcase
  end

  // Stage p0: request capture at the handshake edge
  always_ff @(posedge clk) begin
    if (capture) begin
      write_p0  <= req_write;
      signed_p0 <= req_signed;
      size_p0   <= req_size;
      lane_p0   <= req_addr[1:0];
      wdata_p0  <= req_wdata;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= 32'd0;
      ram_addr       <= 32'd0;
      ram_wdata      <= 32'd0;
      ram_data_read  <= 1'b0;
      ram_data_write <= 1'b0;
    end else begin
      state          <= state_nxt;
      req_ready      <= ready_nxt;
      resp_valid     <= resp_valid_nxt;
      resp_err       <= resp_err_nxt;
      resp_rdata     <= resp_rdata_nxt;
      ram_addr       <= ram_addr_nxt;
      ram_wdata      <= ram_wdata_nxt;
      ram_data_read  <= rd_nxt;
      ram_data_write <= wr_nxt;
    end
  end

endmodule

// File: tb/tb_ram_access_initiator.sv
// Testbench for ram_access_initiator: behavioural RAM, directed requests,
// expected responses queued at the handshake and checked by a monitor.
module tb_ram_access_initiator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_data_read;
  logic        ram_data_write;
  logic [31:0] ram_rdata;

  ram_access_initiator #(.RAM_BYTES(1001)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_data_read(ram_data_read), .ram_data_write(ram_data_write),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: combinational little-endian read, write while strobe high
  logic [7:0]  mem [0:4095];
  logic [11:0] ra;
  assign ra = ram_addr[11:0];
  always_comb ram_rdata = {mem[ra + 12'd3], mem[ra + 12'd2], mem[ra + 12'd1], mem[ra]};
  always @(posedge clk)
    if (ram_data_write) begin
      mem[ra]         = ram_wdata[7:0];
      mem[ra + 12'd1] = ram_wdata[15:8];
      mem[ra + 12'd2] = ram_wdata[23:16];
      mem[ra + 12'd3] = ram_wdata[31:24];
    end

  int compared = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cycles = 0;
  int wr_cycles = 0;
  int overlap = 0;
  logic [31:0] wr_addr_last = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_data_read) rd_cycles++;
    if (ram_data_write) begin
      wr_cycles++;
      wr_addr_last = ram_addr;
    end
    if (ram_data_read && ram_data_write) overlap++;
  end

  typedef struct {
    string       name;
    logic [31:0] d;
    logic        e;
    int          lat;
    int          hs;
  } exp_t;
  exp_t q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops the oldest expectation whenever a response appears
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resp_valid) begin
      if (q.size() == 0) begin
        compared++;
        errors++;
        $display("FAIL unexpected_resp: got rdata 0x%08h err %0b, expected no response", resp_rdata, resp_err);
      end else begin
        e = q.pop_front();
        check({e.name, " rdata"}, resp_rdata, e.d);
        check({e.name, " err"}, {31'd0, resp_err}, {31'd0, e.e});
        check({e.name, " latency"}, 32'(cyc - e.hs), 32'(e.lat));
      end
    end
  end

  task automatic issue(input string nm, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                       input bit push);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      compared++;
      errors++;
      $display("FAIL %s ready_timeout: got req_ready 0, expected 1 within 50 cycles", nm);
      return;
    end
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) q.push_back('{nm, exp_d, exp_e, exp_lat, cyc - 1});
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (q.size() != 0) begin
      compared++;
      errors++;
      $display("FAIL %s resp_timeout: got %0d pending responses, expected 0", nm, q.size());
      q.delete();
    end
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rd0, wr0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    {mem[32'h23], mem[32'h22], mem[32'h21], mem[32'h20]} = 32'h8081_7F01;
    {mem[32'h33], mem[32'h32], mem[32'h31], mem[32'h30]} = 32'h1122_3344;
    {mem[32'h3E7], mem[32'h3E6], mem[32'h3E5], mem[32'h3E4]} = 32'hCAFE_F00D;
    {mem[32'h3EB], mem[32'h3EA], mem[32'h3E9], mem[32'h3E8]} = 32'h0BAD_F00D;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst req_ready", {31'd0, req_ready}, 32'd1);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst resp_err", {31'd0, resp_err}, 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst ram_addr", ram_addr, 32'd0);
    check("rst ram_wdata", ram_wdata, 32'd0);
    check("rst ram_data_read", {31'd0, ram_data_read}, 32'd0);
    check("rst ram_data_write", {31'd0, ram_data_write}, 32'd0);
    #1 rst_n = 1'b1;

    // Word store then load back
    wr0 = wr_cycles;
    issue("SW 0x10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 1'b1);
    drain("SW 0x10");
    check("SW write_strobe_cycles", 32'(wr_cycles - wr0), 32'd1);
    check("SW write_addr", wr_addr_last, 32'h10);
    check("SW mem_word", mem_word(32'h10), 32'hDEAD_BEEF);
    issue("LW 0x10", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, 1'b1);

    // Sub-word loads with sign/zero extension
    issue("LB 0x22", 1'b0, 2'd0, 1'b1, 32'h22, 32'd0, 32'hFFFF_FF81, 1'b0, 2, 1'b1);
    issue("LBU 0x22", 1'b0, 2'd0, 1'b0, 32'h22, 32'd0, 32'h0000_0081, 1'b0, 2, 1'b1);
    issue("LB 0x21", 1'b0, 2'd0, 1'b1, 32'h21, 32'd0, 32'h0000_007F, 1'b0, 2, 1'b1);
    issue("LH 0x20", 1'b0, 2'd1, 1'b1, 32'h20, 32'd0, 32'h0000_7F01, 1'b0, 2, 1'b1);
    issue("LH 0x22", 1'b0, 2'd1, 1'b1, 32'h22, 32'd0, 32'hFFFF_8081, 1'b0, 2, 1'b1);
    issue("LHU 0x22", 1'b0, 2'd1, 1'b0, 32'h22, 32'd0, 32'h0000_8081, 1'b0, 2, 1'b1);
    drain("loads");

    // Read-modify-write stores
    rd0 = rd_cycles; wr0 = wr_cycles;
    issue("SB 0x31", 1'b1, 2'd0, 1'b0, 32'h31, 32'h0000_00AB, 32'd0, 1'b0, 3, 1'b1);
    drain("SB 0x31");
    check("SB read_strobe_cycles", 32'(rd_cycles - rd0), 32'd1);
    check("SB write_strobe_cycles", 32'(wr_cycles - wr0), 32'd1);
    check("SB write_addr", wr_addr_last, 32'h30);
    check("SB mem_word", mem_word(32'h30), 32'h1122_AB44);
    issue("SH 0x32", 1'b1, 2'd1, 1'b0, 32'h32, 32'h1234_BEEF, 32'd0, 1'b0, 3, 1'b1);
    issue("LW 0x30", 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 32'hBEEF_AB44, 1'b0, 2, 1'b1);
    drain("SH/LW 0x30");

    // Error requests: no strobes, 1-cycle response
    rd0 = rd_cycles; wr0 = wr_cycles;
    issue("LW 0x13", 1'b0, 2'd2, 1'b0, 32'h13, 32'd0, 32'd0, 1'b1, 1, 1'b1);
    issue("SH 0x15", 1'b1, 2'd1, 1'b0, 32'h15, 32'h55, 32'd0, 1'b1, 1, 1'b1);
    issue("size3 0x20", 1'b0, 2'd3, 1'b0, 32'h20, 32'd0, 32'd0, 1'b1, 1, 1'b1);
    drain("errors");
    check("err read_strobe_cycles", 32'(rd_cycles - rd0), 32'd0);
    check("err write_strobe_cycles", 32'(wr_cycles - wr0), 32'd0);
    check("err mem_word 0x14", mem_word(32'h14), 32'd0);

    // Range boundary
    issue("LW 0x3E4", 1'b0, 2'd2, 1'b0, 32'h3E4, 32'd0, 32'hCAFE_F00D, 1'b0, 2, 1'b1);
`ifdef RAM_ACCESS_RANGE_CHECK_EN
    issue("LW 0x3E8", 1'b0, 2'd2, 1'b0, 32'h3E8, 32'd0, 32'd0, 1'b1, 1, 1'b1);
`else
    issue("LW 0x3E8", 1'b0, 2'd2, 1'b0, 32'h3E8, 32'd0, 32'h0BAD_F00D, 1'b0, 2, 1'b1);
`endif
    drain("range");

    // Reset during the WRITE cycle of a byte store: no response
    issue("SB 0x35 abort", 1'b1, 2'd0, 1'b0, 32'h35, 32'h5A, 32'd0, 1'b0, 3, 1'b0);
    @(posedge clk);
    #1;
    check("abort in_write ram_data_write", {31'd0, ram_data_write}, 32'd1);
    check("abort in_write ram_addr", ram_addr, 32'h34);
    #2 rst_n = 1'b0;
    #1;
    check("abort ram_data_write", {31'd0, ram_data_write}, 32'd0);
    check("abort ram_data_read", {31'd0, ram_data_read}, 32'd0);
    check("abort resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("abort req_ready", {31'd0, req_ready}, 32'd1);
    repeat (5) @(negedge clk);
    issue("LW 0x10 post", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, 1'b1);
    drain("post reset");

    check("strobe_overlap_cycles", 32'(overlap), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end
endmodule

// File: doc/ram_access_initiator.md
Name: ram_access_initiator

Overview:
- CPU-side master for the byte-addressed, little-endian data RAM (combinational read, level-sensitive write, 4 bytes at addr..addr+3).
- Accepts one load/store request at a time from the CPU datapath and sequences the RAM strobes.
- Guarantees read and write strobes are never high together, and performs read-modify-write for byte and halfword stores.
- Returns sign- or zero-extended load data for MIPS LB/LBU/LH/LHU/LW and completes SB/SH/SW.

Parameters:
- RAM_BYTES, 1001, number of addressable RAM bytes; an access is in range iff the byte address of its highest addressed byte ≤ RAM_BYTES-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  initiator can accept a request
- req_write  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=halfword, 2=word, 3=reserved (error)
- req_signed  in  1  sign-extend load result (ignored for stores and words)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned, reserved size, or out-of-range; qualified by resp_valid
- ram_addr  out  32  to RAM addr
- ram_wdata  out  32  to RAM data_in
- ram_data_read  out  1  to RAM data_read
- ram_data_write  out  1  to RAM data_write
- ram_rdata  in  32  from RAM data_out

Behaviour:
- All outputs are registered. Reset drives every output to 0 except req_ready, which resets to 1. State resets to IDLE.
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. Handshake is req_valid&&req_ready at a rising edge; request fields are captured at that edge.
- Error request:
  - Conditions: size 3; half with addr[0]=1; word with addr[1:0]≠0; out-of-range (see optional feature).
  - Go to RESP with err=1. No RAM strobe is asserted.
- Load, or byte/half store: go to READ. Set ram_addr={addr[31:2],2'b00} and ram_data_read=1.
- Word store: go to WRITE. Set ram_addr=addr, ram_wdata=req_wdata, ram_data_write=1.
- READ (1 cycle):
  - Capture ram_rdata at the clock edge and drop ram_data_read.
  - Load: extract the lane selected by addr[1:0], extend per req_signed, go to RESP.
  - Store: replace the selected byte/half lane of the captured word with req_wdata, load ram_wdata, set ram_data_write=1, go to WRITE.
  - ram_addr is unchanged.
- WRITE (exactly 1 cycle): ram_addr and ram_wdata are stable for the whole cycle. Next edge drops ram_data_write, go to RESP.
- RESP (1 cycle):
  - resp_valid=1 with resp_rdata/resp_err. req_ready=0. ram_addr is held at its last value, so the address never changes in the same edge that the write strobe falls.
  - Next edge: resp_valid=0, req_ready=1, IDLE.
- Latency, handshake edge to resp_valid:
  - LW/LB/LH and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- Throughput: at most one request in flight. No response backpressure; the CPU must sample resp_valid.
- ram_data_read and ram_data_write are never 1 in the same cycle. Both are 0 in IDLE and RESP.
- Reset asserted mid-operation: strobes drop immediately, and no response is issued for the aborted request. A store aborted in WRITE may have partially updated RAM; this is accepted.
- req_valid while not ready is ignored. The request is not queued.

Optional Feature:
- RAM_ACCESS_RANGE_CHECK_EN
  - Defined: a request whose highest byte is ≥ RAM_BYTES is flagged as an error in the 1-cycle error path, with no RAM access.
  - Undefined: no range check; out-of-range requests proceed to the RAM normally.

Test Plan:
- SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> write strobe high exactly 1 cycle with ram_addr=0x10; LW returns 0xDEADBEEF, 2 cycles after each handshake.
- RAM[0x20..0x23]=0x8081_7F01:
  - LB 0x22 -> 0xFFFFFF81.
  - LBU 0x22 -> 0x00000081.
  - LH 0x20 -> 0x00007F01.
  - LH 0x22 -> 0xFFFF8081.
- RAM word at 0x30 = 0x11223344; SB addr=0x31 data=0xAB -> read-then-write; written word 0x1122AB44; resp_valid 3 cycles after handshake; strobes never overlap.
- LW 0x13 and SH 0x15 -> resp_err=1 at cycle 1; ram_data_read and ram_data_write stay 0.
- With RAM_ACCESS_RANGE_CHECK_EN defined, RAM_BYTES=1001:
  - LW 0x3E4 (bytes 996..999) -> ok.
  - LW 0x3E8 (bytes 1000..1003) -> resp_err=1.
- rst_n pulled low during the WRITE cycle of an SB -> ram_data_write=0 asynchronously, no resp_valid, req_ready=1 after release.
